// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: register map, bit positions,
// FSM encoding and prescaler limits.
package fib_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STEPS  = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_VALUE  = 5'h0C;
  localparam logic [4:0] OFF_IRQ_EN = 5'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_CONT     = 2;
  localparam int CTRL_RATE_LSB = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [2:0] RATE_MAX   = 3'd5;
  localparam int         PRESCALE_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } fib_state_e;

  // RATE codes above the maximum behave as the slowest supported rate.
  function automatic logic [2:0] clamp_rate(input logic [2:0] rate);
    if (rate > RATE_MAX) begin
      return RATE_MAX;
    end else begin
      return rate;
    end
  endfunction

endpackage

// File: rtl/fib_tickgen.sv
// Free-running prescaler that emits a tick every 2^(4*rate) clock cycles.
module fib_tickgen
  import fib_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] rate,
  output logic       tick
);

  logic [PRESCALE_W-1:0] count_r;
  logic [PRESCALE_W-1:0] mask_s;

  // Low-order count bits that must all be set for a tick at this rate
  always_comb begin
    mask_s = 20'h0_0000;
    case (clamp_rate(rate))
      3'd0:    mask_s = 20'h0_0000;
      3'd1:    mask_s = 20'h0_000F;
      3'd2:    mask_s = 20'h0_00FF;
      3'd3:    mask_s = 20'h0_0FFF;
      3'd4:    mask_s = 20'h0_FFFF;
      default: mask_s = 20'hF_FFFF;
    endcase
  end

  // Prescaler counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 20'h0_0000;
    end else if (clear) begin
      count_r <= 20'h0_0000;
    end else begin
      count_r <= count_r + 20'h0_0001;
    end
  end

  assign tick = ((count_r & mask_s) == mask_s);

endmodule

// File: rtl/fib_sequencer.sv
// Wishbone-controlled sequencer that drives an external Fibonacci datapath
// through clear/step strobes, with completion and overflow status.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 30
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [WIDTH-1:0] fib_value,
  output logic             fib_clear,
  output logic             fib_step,
  output logic             busy,
  output logic [2:0]       irq
);

  fib_state_e state_r, state_next_s;

  logic             ack_r;
  logic [31:0]      dat_r;
  logic             cont_r;
  logic [2:0]       rate_r;
  logic [15:0]      steps_r;
  logic [15:0]      remaining_r;
  logic [1:0]       irq_en_r;
  logic             done_r;
  logic             ovf_r;
  logic [WIDTH-1:0] prev_r;

  logic [31:0] off_s;
  logic [4:0]  reg_off_s;
  logic        in_range_s, acc_s, wr_s;
  logic        wr_ctrl_s, wr_steps_s, wr_status_s, wr_irq_en_s;
  logic        start_s, stop_s;
  logic        clr_done_s, clr_ovf_s;
  logic        tick_s, ovf_hit_s, run_done_s;
  logic        set_done_s, set_ovf_s, presc_clear_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  assign unused_s = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // Address decode and write strobes; ack_r blocks back-to-back accesses
  always_comb begin
    off_s       = wbs_adr_i - BASE_ADDR;
    in_range_s  = (wbs_adr_i >= BASE_ADDR) && (off_s < 32'h0000_0020);
    reg_off_s   = {off_s[4:2], 2'b00};
    acc_s       = wbs_stb_i && wbs_cyc_i && in_range_s && !ack_r;
    wr_s        = acc_s && wbs_we_i;
    wr_ctrl_s   = wr_s && (reg_off_s == OFF_CTRL) && wbs_sel_i[0];
    wr_steps_s  = wr_s && (reg_off_s == OFF_STEPS);
    wr_status_s = wr_s && (reg_off_s == OFF_STATUS) && wbs_sel_i[0];
    wr_irq_en_s = wr_s && (reg_off_s == OFF_IRQ_EN) && wbs_sel_i[0];
    start_s     = wr_ctrl_s && wbs_dat_i[CTRL_START] && !wbs_dat_i[CTRL_STOP];
    stop_s      = wr_ctrl_s && wbs_dat_i[CTRL_STOP];
    clr_done_s  = wr_status_s && wbs_dat_i[STAT_DONE];
    clr_ovf_s   = wr_status_s && wbs_dat_i[STAT_OVF];
  end

  // Register read mux
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (reg_off_s)
      OFF_CTRL:   rd_data_s = {25'h0, rate_r, 1'b0, cont_r, 2'b00};
      OFF_STEPS:  rd_data_s = {16'h0000, steps_r};
      OFF_STATUS: rd_data_s = {29'h0, ovf_r, done_r, busy};
      OFF_VALUE:  rd_data_s = 32'(fib_value);
      OFF_IRQ_EN: rd_data_s = {30'h0, irq_en_r};
      default:    rd_data_s = 32'h0000_0000;
    endcase
  end

  // Bus response registers
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= acc_s;
      dat_r <= (acc_s && !wbs_we_i) ? rd_data_s : 32'h0000_0000;
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      cont_r   <= 1'b0;
      rate_r   <= 3'd0;
      steps_r  <= 16'h0000;
      irq_en_r <= 2'b00;
    end else begin
      if (wr_ctrl_s) begin
        cont_r <= wbs_dat_i[CTRL_CONT];
        rate_r <= clamp_rate(wbs_dat_i[CTRL_RATE_LSB +: 3]);
      end
      if (wr_steps_s && wbs_sel_i[0]) steps_r[7:0]  <= wbs_dat_i[7:0];
      if (wr_steps_s && wbs_sel_i[1]) steps_r[15:8] <= wbs_dat_i[15:8];
      if (wr_irq_en_s) irq_en_r <= wbs_dat_i[1:0];
    end
  end

  // Sticky status bits; a hardware set overrides a simultaneous clear
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= (done_r && !clr_done_s) || set_done_s;
      ovf_r  <= (ovf_r && !clr_ovf_s) || set_ovf_s;
    end
  end

  assign presc_clear_s = (state_r == ST_CLEAR) || wr_ctrl_s;

  fib_tickgen u_tickgen (
    .clk   (wb_clk_i),
    .reset (reset),
    .clear (presc_clear_s),
    .rate  (rate_r),
    .tick  (tick_s)
  );

  assign ovf_hit_s  = (fib_value < prev_r);
  assign run_done_s = !cont_r && (remaining_r == 16'h0000);

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; STOP outranks START, which outranks completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next_s = ST_CLEAR;
        else         state_next_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (stop_s)                                  state_next_s = ST_IDLE;
        else if (start_s)                            state_next_s = ST_CLEAR;
        else if ((steps_r == 16'h0000) && !cont_r)   state_next_s = ST_IDLE;
        else                                         state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (stop_s)                       state_next_s = ST_IDLE;
        else if (start_s)                 state_next_s = ST_CLEAR;
        else if (ovf_hit_s || run_done_s) state_next_s = ST_IDLE;
        else                              state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs and status set strobes
  always_comb begin
    fib_clear  = 1'b0;
    fib_step   = 1'b0;
    set_done_s = 1'b0;
    set_ovf_s  = 1'b0;
    busy       = (state_r != ST_IDLE);
    case (state_r)
      ST_CLEAR: begin
        fib_clear  = 1'b1;
        set_done_s = !stop_s && !start_s && (steps_r == 16'h0000) && !cont_r;
      end
      ST_RUN: begin
        if (!stop_s && !start_s) begin
          set_ovf_s  = ovf_hit_s;
          set_done_s = !ovf_hit_s && run_done_s;
          fib_step   = !ovf_hit_s && !run_done_s && tick_s;
        end else begin
          set_ovf_s  = 1'b0;
          set_done_s = 1'b0;
          fib_step   = 1'b0;
        end
      end
      default: begin
        fib_clear = 1'b0;
        fib_step  = 1'b0;
      end
    endcase
  end

  // Step budget and overflow comparison history
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      remaining_r <= 16'h0000;
      prev_r      <= '0;
    end else begin
      if (state_r == ST_CLEAR) begin
        remaining_r <= steps_r;
        prev_r      <= '0;
      end else begin
        prev_r <= fib_value;
        if (fib_step && !cont_r) remaining_r <= remaining_r - 16'h0001;
      end
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq       = {1'b0, ovf_r && irq_en_r[1], done_r && irq_en_r[0]};

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench: register table, directed sequences and randomized runs
// against a behavioural Fibonacci datapath and arithmetic reference.
module tb_fib_sequencer;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          W     = 30;
  localparam logic [63:0] VMASK = (64'd1 << W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = 32'h0, adr = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [W-1:0] fib_value;
  logic        fib_clear, fib_step, busy;
  logic [2:0]  irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  fib_sequencer #(.BASE_ADDR(BASE), .WIDTH(W)) dut (
    .wb_clk_i(clk), .reset(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .fib_value(fib_value), .fib_clear(fib_clear), .fib_step(fib_step),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: seed (0,1), advanced by the sequencer strobes
  logic [63:0] fa = 64'd0;
  logic [63:0] fb = 64'd1;
  assign fib_value = fa[W-1:0];
  always @(posedge clk) begin
    if (fib_clear) begin
      fa <= 64'd0;
      fb <= 64'd1;
    end else if (fib_step) begin
      fa <= fb;
      fb <= (fa + fb) & VMASK;
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int step_q[$];
  int clear_cnt = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (fib_step) step_q.push_back(cycle);
    if (fib_clear) clear_cnt <= clear_cnt + 1;
    if ((fib_step && fib_clear) || (!busy && (fib_step || fib_clear))) viol <= viol + 1;
  end

  function automatic logic [63:0] fib_ref(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = (a + b) & VMASK;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] r, output logic acked);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; wdat = d; adr = a;
    acked = 1'b0;
    r = 32'h0;
    for (int i = 0; i < 6 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        acked = 1'b1;
        r = rdat;
      end
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic acked;
    wb_cycle(BASE + 32'(off), 1'b1, s, d, r, acked);
    check($sformatf("wr_ack_%0h", off), 32'(acked), 32'd1);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] r);
    logic acked;
    wb_cycle(BASE + 32'(off), 1'b0, 4'hF, 32'h0, r, acked);
    check($sformatf("rd_ack_%0h", off), 32'(acked), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_steps(input string name, input int target, input int budget);
    int n = 0;
    while (step_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(step_q.size() >= target), 32'd1);
  endtask

  task automatic check_intervals(input string name, input int base, input int period);
    int bad = 0;
    for (int i = base + 1; i < step_q.size(); i++)
      if (step_q[i] - step_q[i-1] != period) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]  off;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [31:0] r;
    logic acked;
    int base, cbase, snap, n, rate, nwrap;

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", 32'(fib_step), 32'd0);
    check("rst_clear", 32'(fib_clear), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    vecs.push_back('{8'h00, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h04, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h08, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h0C, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h10, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h04, 1'b1, 4'h3, 32'hFFFF_1234, 32'h0});
    vecs.push_back('{8'h04, 1'b0, 4'hF, 32'h0, 32'h0000_1234});
    vecs.push_back('{8'h04, 1'b1, 4'h2, 32'h0000_ABCD, 32'h0});
    vecs.push_back('{8'h04, 1'b0, 4'hF, 32'h0, 32'h0000_AB34});
    vecs.push_back('{8'h10, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{8'h10, 1'b0, 4'hF, 32'h0, 32'h0000_0003});
    vecs.push_back('{8'h10, 1'b1, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h00, 1'b1, 4'hF, 32'h0000_0074, 32'h0});
    vecs.push_back('{8'h00, 1'b0, 4'hF, 32'h0, 32'h0000_0054});
    vecs.push_back('{8'h00, 1'b1, 4'hE, 32'h0000_0000, 32'h0});
    vecs.push_back('{8'h00, 1'b0, 4'hF, 32'h0, 32'h0000_0054});
    vecs.push_back('{8'h00, 1'b1, 4'hF, 32'h0000_0000, 32'h0});
    vecs.push_back('{8'h1C, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{8'h1C, 1'b0, 4'hF, 32'h0, 32'h0});
    vecs.push_back('{8'h14, 1'b0, 4'hF, 32'h0, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].w) begin
        wb_write(vecs[i].off, vecs[i].d, vecs[i].s);
      end else begin
        wb_read(vecs[i].off, r);
        check($sformatf("vec%0d_rd_%0h", i, vecs[i].off), r, vecs[i].exp);
      end
    end

    // Ten consecutive steps at full rate
    wb_write(8'h04, 32'd10, 4'hF);
    base = step_q.size();
    wb_write(8'h00, 32'h01, 4'hF);
    wait_idle("a_idle", 100);
    check("a_count", 32'(step_q.size() - base), 32'd10);
    check_intervals("a_consecutive", base, 1);
    wb_read(8'h0C, r);
    check("a_value", r, 32'd55);
    wb_read(8'h08, r);
    check("a_status", r, 32'h2);
    wb_write(8'h08, 32'h2, 4'h1);

    // Slow rate, done interrupt and its W1C
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h10, 32'h1, 4'hF);
    base = step_q.size();
    wb_write(8'h00, 32'h11, 4'hF);
    wait_idle("b_idle", 200);
    check("b_count", 32'(step_q.size() - base), 32'd3);
    check_intervals("b_period16", base, 16);
    wb_read(8'h08, r);
    check("b_status", r, 32'h2);
    check("b_irq_set", 32'(irq), 32'h1);
    wb_write(8'h08, 32'h2, 4'h1);
    check("b_irq_clr", 32'(irq), 32'h0);
    wb_write(8'h10, 32'h0, 4'hF);

    // Randomized step counts and rates
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 12));
      rate = int'($urandom_range(0, 1));
      wb_write(8'h04, 32'(n), 4'hF);
      base = step_q.size();
      wb_write(8'h00, 32'((rate << 4) | 1), 4'hF);
      wait_idle($sformatf("r%0d_idle", it), 400);
      check($sformatf("r%0d_count", it), 32'(step_q.size() - base), 32'(n));
      check_intervals($sformatf("r%0d_period", it), base, 1 << (4 * rate));
      wb_read(8'h0C, r);
      check($sformatf("r%0d_value", it), r, fib_ref(n)[31:0]);
      wb_read(8'h08, r);
      check($sformatf("r%0d_status", it), r, 32'h2);
      wb_write(8'h08, 32'h2, 4'h1);
    end

    // Continuous run until the datapath wraps
    nwrap = 2;
    while (fib_ref(nwrap) >= fib_ref(nwrap - 1)) nwrap++;
    wb_write(8'h10, 32'h2, 4'hF);
    base = step_q.size();
    wb_write(8'h00, 32'h05, 4'hF);
    wait_idle("c_idle", 200);
    check("c_count", 32'(step_q.size() - base), 32'(nwrap));
    wb_read(8'h0C, r);
    check("c_value", r, fib_ref(nwrap)[31:0]);
    wb_read(8'h08, r);
    check("c_status", r, 32'h4);
    check("c_irq", 32'(irq), 32'h2);
    snap = step_q.size();
    repeat (10) @(negedge clk);
    check("c_no_more", 32'(step_q.size() - snap), 32'd0);
    wb_write(8'h08, 32'h6, 4'h1);
    wb_write(8'h00, 32'h0, 4'hF);
    wb_write(8'h10, 32'h0, 4'hF);

    // STOP after five steps, then a zero-step START
    wb_write(8'h04, 32'd100, 4'hF);
    base = step_q.size();
    wb_write(8'h00, 32'h11, 4'hF);
    wait_steps("d_reach5", base + 5, 200);
    wb_write(8'h00, 32'h12, 4'hF);
    check("d_busy", 32'(busy), 32'd0);
    wb_read(8'h08, r);
    check("d_status", r, 32'h0);
    repeat (40) @(negedge clk);
    check("d_count", 32'(step_q.size() - base), 32'd5);
    wb_write(8'h04, 32'd0, 4'hF);
    base = step_q.size();
    cbase = clear_cnt;
    wb_write(8'h00, 32'h01, 4'hF);
    wait_idle("d0_idle", 20);
    repeat (2) @(negedge clk);
    check("d0_clears", 32'(clear_cnt - cbase), 32'd1);
    check("d0_steps", 32'(step_q.size() - base), 32'd0);
    wb_read(8'h08, r);
    check("d0_status", r, 32'h2);

    // Reset in the middle of a run
    wb_write(8'h10, 32'h1, 4'hF);
    wb_write(8'h04, 32'd50, 4'hF);
    base = step_q.size();
    wb_write(8'h00, 32'h01, 4'hF);
    check("e_irq_before", 32'(irq), 32'h1);
    wait_steps("e_reach3", base + 3, 50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("e_busy", 32'(busy), 32'd0);
    check("e_step", 32'(fib_step), 32'd0);
    check("e_clear", 32'(fib_clear), 32'd0);
    check("e_irq", 32'(irq), 32'd0);
    check("e_ack", 32'(ack), 32'd0);
    snap = step_q.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("e_no_steps", 32'(step_q.size() - snap), 32'd0);
    wb_read(8'h04, r);
    check("e_steps_reg", r, 32'h0);
    wb_read(8'h08, r);
    check("e_status", r, 32'h0);

    // Out-of-range accesses must not be acknowledged
    wb_cycle(BASE + 32'h20, 1'b0, 4'hF, 32'h0, r, acked);
    check("f_above", 32'(acked), 32'd0);
    wb_cycle(BASE - 32'h4, 1'b1, 4'hF, 32'h1, r, acked);
    check("f_below", 32'(acked), 32'd0);
    check("f_busy", 32'(busy), 32'd0);

    check("strobe_rules", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the register block.
REQ-002 SHALL have parameter WIDTH, default 30, width of the Fibonacci value being sequenced.
REQ-003 SHALL have ports, in order: wb_clk_i in 1 (single clock); reset in 1 (asynchronous, active-high).
REQ-004 SHALL have Wishbone slave ports: wbs_stb_i in 1, wbs_cyc_i in 1, wbs_we_i in 1, wbs_sel_i in 4, wbs_dat_i in 32, wbs_adr_i in 32, wbs_ack_o out 1, wbs_dat_o out 32.
REQ-005 SHALL have datapath ports: fib_value in WIDTH (current datapath value); fib_clear out 1 (reload seed); fib_step out 1 (advance one term); busy out 1; irq out 3.

Function
REQ-006 Registers, byte offsets from BASE_ADDR: 0x00 CTRL, 0x04 STEPS[15:0], 0x08 STATUS, 0x0C VALUE (RO, zero-extended fib_value), 0x10 IRQ_EN[1:0].
REQ-007 CTRL: bit0 START (write-1 pulse), bit1 STOP (write-1 pulse), bit2 CONT (stored), bits[6:4] RATE (stored, 0..5); START/STOP read back 0.
REQ-008 STATUS: bit0 busy (RO), bit1 DONE, bit2 OVF; DONE/OVF sticky, write-1-to-clear.
REQ-009 Access: stb&cyc&address in [BASE_ADDR, BASE_ADDR+0x1F] -> wbs_ack_o high exactly one cycle on the next edge; ack deasserted at least one cycle between accesses; out-of-range -> no ack.
REQ-010 Writes honour wbs_sel_i per byte; read data valid in ack cycle; unmapped in-range offsets read 0, writes ignored.
REQ-011 Tick: internal 20-bit prescaler; tick every 2^(4*RATE) cycles (RATE 0 = every cycle); RATE 6/7 treated as 5; prescaler cleared on entry to RUN and on any RATE write.
REQ-012 FSM states IDLE, CLEAR, RUN.
REQ-013 IDLE -> CLEAR on START; CLEAR lasts one cycle, fib_clear=1, remaining<=STEPS, OVF compare history cleared.
REQ-014 CLEAR -> IDLE with DONE set if STEPS=0 and CONT=0; else -> RUN.
REQ-015 RUN: on each tick fib_step=1 for one cycle, remaining decremented unless CONT=1.
REQ-016 RUN -> IDLE with DONE set in the cycle after the step that takes remaining to 0.
REQ-017 Overflow: prev register samples fib_value every cycle; in RUN, fib_value < prev -> OVF set, RUN -> IDLE, no further fib_step.
REQ-018 STOP in RUN or CLEAR -> IDLE next cycle, DONE not set; START and STOP in same write -> STOP wins.
REQ-019 START while busy -> restart via CLEAR (remaining reloaded).
REQ-020 Hardware set and W1C of the same STATUS bit in one cycle -> bit stays set.
REQ-021 busy = (state != IDLE); fib_step and fib_clear never high in the same cycle; both low in IDLE.
REQ-022 irq[0] = DONE & IRQ_EN[0]; irq[1] = OVF & IRQ_EN[1]; irq[2] = 0; level outputs.

Reset
REQ-023 reset high SHALL asynchronously force IDLE, all registers 0, prescaler 0, remaining 0, prev 0.
REQ-024 During reset, wbs_ack_o, wbs_dat_o, fib_clear, fib_step, busy, irq SHALL be 0.
REQ-025 Reset mid-RUN SHALL abort immediately with no further fib_step after deassertion until a new START.

Structure
REQ-026 Shared package fib_pkg SHALL hold register offsets, CTRL/STATUS bit indices, FSM state encoding and the RATE maximum.
REQ-027 Prescaler SHALL be the sub-module fib_tickgen (inputs clk, reset, clear, rate; output tick).
REQ-028 Wishbone decode and FSM SHALL reside in fib_sequencer.

Verification
REQ-029 Bench SHALL use a behavioural Fibonacci model (seed 0,1) driven by fib_clear/fib_step.
REQ-030 STEPS=10, RATE=0, CONT=0, START -> exactly 10 fib_step pulses on consecutive cycles, VALUE=55, DONE=1, busy=0.
REQ-031 STEPS=3, RATE=1, START -> fib_step every 16 cycles, 3 pulses, DONE=1; IRQ_EN=1 -> irq[0]=1; W1C STATUS 0x2 -> irq[0]=0.
REQ-032 CONT=1, RATE=0, WIDTH=30, START -> stepping until wrap past 2^30, OVF=1, irq[1]=1 when enabled, fib_step stops.
REQ-033 STEPS=100, START, STOP after 5 steps -> IDLE, DONE=0, no further pulses; START with STEPS=0 -> fib_clear only, DONE=1.
REQ-034 reset asserted mid-RUN -> outputs 0 immediately; out-of-range address -> no ack; read 0x1C -> 0 with ack.
